// File: rtl/fpu_pkg.sv
// Shared constants for the normalizer scheduler slice: default field widths,
// source encodings and the completed-result counter width.
package fpu_pkg;

    localparam int SIZE_MANTISSA = 23;
    localparam int SIZE_EXPONENT = 8;
    localparam int SIZE_TAG      = 4;
    localparam int RES_CNT_W     = 16;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage : fpu_pkg

// File: rtl/fpu_normalizer.sv
// Combinational mantissa normalizer: resolves a carry with a right shift,
// otherwise left-shifts by the leading-zero count so the hidden bit is set.
module fpu_normalizer #(
    parameter int Size_Mantissa = 23,
    parameter int Size_Exponent = 8
) (
    input  logic [Size_Mantissa+1:0] i_mantissa,
    input  logic [Size_Exponent-1:0] i_exponent,
    output logic [Size_Mantissa-1:0] o_mantissa,
    output logic [Size_Exponent-1:0] o_exponent,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int LZ_W = $clog2(Size_Mantissa + 2);

    logic [LZ_W-1:0]          w_lz;
    logic                     w_found;
    logic [Size_Mantissa+1:0] w_shl;
    logic [Size_Mantissa+1:0] w_shr;
    logic [Size_Exponent:0]   w_exp_inc;

    // Leading-zero count over bits [M:0]; an all-zero field counts as M+1.
    always_comb begin
        w_lz    = LZ_W'(Size_Mantissa + 1);
        w_found = 1'b0;
        for (int i = Size_Mantissa; i >= 0; i--) begin
            if (!w_found && i_mantissa[i]) begin
                w_lz    = LZ_W'(Size_Mantissa - i);
                w_found = 1'b1;
            end
        end
    end

    assign w_shl     = i_mantissa << w_lz;
    assign w_shr     = i_mantissa >> 1;
    assign w_exp_inc = {1'b0, i_exponent} + {{Size_Exponent{1'b0}}, 1'b1};

    // Select carry or left-shift result; hidden bit is dropped from the output.
    always_comb begin
        if (i_mantissa[Size_Mantissa+1]) begin
            o_mantissa  = w_shr[Size_Mantissa-1:0];
            o_exponent  = w_exp_inc[Size_Exponent-1:0];
            o_overflow  = (w_exp_inc >= {1'b0, {Size_Exponent{1'b1}}});
            o_underflow = 1'b0;
        end else begin
            o_mantissa  = w_shl[Size_Mantissa-1:0];
            o_exponent  = i_exponent - Size_Exponent'(w_lz);
            o_overflow  = 1'b0;
            o_underflow = (i_mantissa == '0) || (int'(w_lz) >= int'(i_exponent));
        end
    end

endmodule : fpu_normalizer

// File: rtl/fpu_norm_scheduler.sv
// Round-robin share of one fpu_normalizer between the adder (A) and
// multiplier (B) paths, with a one-entry registered, tagged result stage.
module fpu_norm_scheduler
    import fpu_pkg::*;
#(
    parameter int Size_Mantissa = SIZE_MANTISSA,
    parameter int Size_Exponent = SIZE_EXPONENT,
    parameter int Size_Tag      = SIZE_TAG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [Size_Mantissa+1:0] a_mantissa,
    input  logic [Size_Exponent-1:0] a_exponent,
    input  logic [Size_Tag-1:0]      a_tag,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [Size_Mantissa+1:0] b_mantissa,
    input  logic [Size_Exponent-1:0] b_exponent,
    input  logic [Size_Tag-1:0]      b_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_src,
    output logic [Size_Tag-1:0]      out_tag,
    output logic [Size_Mantissa-1:0] out_mantissa,
    output logic [Size_Exponent-1:0] out_exponent,
    output logic                     out_overflow,
    output logic                     out_underflow,
    output logic [RES_CNT_W-1:0]     res_count
);

    logic                     r_out_valid;
    logic                     r_out_src;
    logic [Size_Tag-1:0]      r_out_tag;
    logic [Size_Mantissa-1:0] r_out_mantissa;
    logic [Size_Exponent-1:0] r_out_exponent;
    logic                     r_out_overflow;
    logic                     r_out_underflow;
    logic [RES_CNT_W-1:0]     r_res_count;
    logic                     r_prio;

    logic                     w_slot_free;
    logic                     w_grant_valid;
    logic                     w_grant_src;
    logic                     w_accept;
    logic                     w_out_fire;
    logic [Size_Mantissa+1:0] w_mantissa;
    logic [Size_Exponent-1:0] w_exponent;
    logic [Size_Tag-1:0]      w_tag;
    logic [Size_Mantissa-1:0] w_norm_mantissa;
    logic [Size_Exponent-1:0] w_norm_exponent;
    logic                     w_norm_overflow;
    logic                     w_norm_underflow;

    // Arbitration: a lone requester wins; under contention r_prio decides.
    always_comb begin
        w_grant_valid = a_valid || b_valid;
        if (a_valid && b_valid) begin
            w_grant_src = r_prio;
        end else if (b_valid) begin
            w_grant_src = SRC_B;
        end else begin
            w_grant_src = SRC_A;
        end
    end

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = w_slot_free && w_grant_valid && !rst;
    assign w_out_fire  = r_out_valid && out_ready;
    assign a_ready     = w_accept && (w_grant_src == SRC_A);
    assign b_ready     = w_accept && (w_grant_src == SRC_B);

    assign w_mantissa = (w_grant_src == SRC_B) ? b_mantissa : a_mantissa;
    assign w_exponent = (w_grant_src == SRC_B) ? b_exponent : a_exponent;
    assign w_tag      = (w_grant_src == SRC_B) ? b_tag      : a_tag;

    fpu_normalizer #(
        .Size_Mantissa (Size_Mantissa),
        .Size_Exponent (Size_Exponent)
    ) u_normalizer (
        .i_mantissa  (w_mantissa),
        .i_exponent  (w_exponent),
        .o_mantissa  (w_norm_mantissa),
        .o_exponent  (w_norm_exponent),
        .o_overflow  (w_norm_overflow),
        .o_underflow (w_norm_underflow)
    );

    // Output stage, fairness pointer and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_src       <= 1'b0;
            r_out_tag       <= '0;
            r_out_mantissa  <= '0;
            r_out_exponent  <= '0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_res_count     <= '0;
            r_prio          <= SRC_A;
        end else begin
            if (w_accept) begin
                r_out_valid     <= 1'b1;
                r_out_src       <= w_grant_src;
                r_out_tag       <= w_tag;
                r_out_mantissa  <= w_norm_mantissa;
                r_out_exponent  <= w_norm_exponent;
                r_out_overflow  <= w_norm_overflow;
                r_out_underflow <= w_norm_underflow;
                r_prio          <= ~w_grant_src;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire) begin
                r_res_count <= r_res_count + RES_CNT_W'(1);
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_src       = r_out_src;
    assign out_tag       = r_out_tag;
    assign out_mantissa  = r_out_mantissa;
    assign out_exponent  = r_out_exponent;
    assign out_overflow  = r_out_overflow;
    assign out_underflow = r_out_underflow;
    assign res_count     = r_res_count;

endmodule : fpu_norm_scheduler

// File: tb/tb_fpu_norm_scheduler.sv
// Directed bench for fpu_norm_scheduler: handshakes, arbitration order,
// back-pressure, normalizer flags and asynchronous reset.
module tb_fpu_norm_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, out_ready;
    logic        a_ready, b_ready;
    logic [24:0] a_mantissa, b_mantissa;
    logic [7:0]  a_exponent, b_exponent;
    logic [3:0]  a_tag, b_tag;
    logic        out_valid, out_src, out_overflow, out_underflow;
    logic [3:0]  out_tag;
    logic [22:0] out_mantissa;
    logic [7:0]  out_exponent;
    logic [15:0] res_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpu_norm_scheduler dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_mantissa(a_mantissa),
        .a_exponent(a_exponent), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_mantissa(b_mantissa),
        .b_exponent(b_exponent), .b_tag(b_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_tag(out_tag), .out_mantissa(out_mantissa), .out_exponent(out_exponent),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .res_count(res_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; a_mantissa = '0; a_exponent = '0; a_tag = '0;
        b_valid = 1'b1; b_mantissa = '0; b_exponent = '0; b_tag = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);

        // Port A carry case
        a_valid = 1'b1; a_mantissa = 25'h1000000; a_exponent = 8'd100; a_tag = 4'd3;
        #1 chk("t1_a_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_src", 32'(out_src), 32'd0);
        chk("t1_out_tag", 32'(out_tag), 32'd3);
        chk("t1_out_mant", 32'(out_mantissa), 32'd0);
        chk("t1_out_exp", 32'(out_exponent), 32'd101);
        chk("t1_out_ovf", 32'(out_overflow), 32'd0);
        chk("t1_out_unf", 32'(out_underflow), 32'd0);
        @(negedge clk);
        chk("t1_res_count", 32'(res_count), 32'd1);
        chk("t1_out_valid_clr", 32'(out_valid), 32'd0);

        // Port B left shift by one
        b_valid = 1'b1; b_mantissa = 25'h0400000; b_exponent = 8'd100; b_tag = 4'd5;
        #1 chk("t2_b_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        b_valid = 1'b0;
        chk("t2_out_src", 32'(out_src), 32'd1);
        chk("t2_out_tag", 32'(out_tag), 32'd5);
        chk("t2_out_mant", 32'(out_mantissa), 32'd0);
        chk("t2_out_exp", 32'(out_exponent), 32'd99);
        chk("t2_out_unf", 32'(out_underflow), 32'd0);
        @(negedge clk);
        chk("t2_res_count", 32'(res_count), 32'd2);

        // Both ports contending from reset: A,B,A,B
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b1; a_mantissa = 25'h0800000; a_exponent = 8'd20; a_tag = 4'd1;
        b_valid = 1'b1; b_mantissa = 25'h0800000; b_exponent = 8'd30; b_tag = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
            chk("t3_out_src", 32'(out_src), 32'(i % 2));
            chk("t3_out_tag", 32'(out_tag), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t3_out_exp", 32'(out_exponent), (i % 2 == 0) ? 32'd20 : 32'd30);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("t3_res_count", 32'(res_count), 32'd4);

        // Back-pressure holds the result and blocks A
        out_ready = 1'b0;
        a_valid = 1'b1; a_mantissa = 25'h0400000; a_exponent = 8'd50; a_tag = 4'd7;
        @(negedge clk);
        a_mantissa = 25'h1000000; a_exponent = 8'd10; a_tag = 4'd8;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_a_ready_low", 32'(a_ready), 32'd0);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_tag", 32'(out_tag), 32'd7);
            chk("t4_hold_exp", 32'(out_exponent), 32'd49);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("t4_a_ready_release", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        chk("t4_new_valid", 32'(out_valid), 32'd1);
        chk("t4_new_tag", 32'(out_tag), 32'd8);
        chk("t4_new_exp", 32'(out_exponent), 32'd11);
        chk("t4_res_count", 32'(res_count), 32'd5);
        @(negedge clk);
        chk("t4_res_count2", 32'(res_count), 32'd6);
        chk("t4_valid_clr", 32'(out_valid), 32'd0);

        // Overflow and underflow flags
        a_valid = 1'b1; a_mantissa = 25'h1000000; a_exponent = 8'd254; a_tag = 4'd9;
        @(negedge clk);
        a_valid = 1'b0;
        chk("t5_ovf", 32'(out_overflow), 32'd1);
        chk("t5_ovf_exp", 32'(out_exponent), 32'hFF);
        chk("t5_ovf_unf", 32'(out_underflow), 32'd0);
        b_valid = 1'b1; b_mantissa = 25'h0000001; b_exponent = 8'd1; b_tag = 4'd10;
        @(negedge clk);
        b_valid = 1'b0;
        chk("t5_unf", 32'(out_underflow), 32'd1);
        chk("t5_unf_ovf", 32'(out_overflow), 32'd0);
        chk("t5_unf_mant", 32'(out_mantissa), 32'd0);
        chk("t5_unf_src", 32'(out_src), 32'd1);
        @(negedge clk);
        chk("t5_res_count", 32'(res_count), 32'd8);

        // Asynchronous reset with a held result; prio was B before reset
        out_ready = 1'b0;
        a_valid = 1'b1; a_mantissa = 25'h0800000; a_exponent = 8'd40; a_tag = 4'd11;
        @(negedge clk);
        chk("t6_held", 32'(out_valid), 32'd1);
        b_valid = 1'b1; b_mantissa = 25'h0800000; b_exponent = 8'd60; b_tag = 4'd12;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_count", 32'(res_count), 32'd0);
        chk("t6_rst_a_ready", 32'(a_ready), 32'd0);
        chk("t6_rst_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("t6_first_a", 32'(a_ready), 32'd1);
        chk("t6_first_b", 32'(b_ready), 32'd0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("t6_out_src", 32'(out_src), 32'd0);
        chk("t6_out_tag", 32'(out_tag), 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fpu_norm_scheduler
